// File: rtl/ser_wr_shifter.sv
// Bus-side serial writer: a CPU write to the serial window loads a word and
// shifts it out MSB- or LSB-first on sdwr/sclk_o, with a pollable busy/overrun status.
module ser_wr_shifter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sser_n,
  input  logic              ba13,
  input  logic              ba12,
  input  logic [3:0]        ba7_4,
  input  logic              br_w,
  input  logic              wr_stb,
  input  logic [DATA_W-1:0] bd_in,
  output logic [7:0]        rd_data,
  output logic              rd_oe,
  output logic              sdwr,
  output logic              sclk_o,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, STOP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        div_q;
  logic              sdwr_q;
  logic              sclk_q;
  logic              busy_q;
  logic              done_q;
  logic              ovr_q;
  logic              lsb_first_q;
  logic              dir_q;

  logic sel;
  logic bus_wr;
  logic bus_rd;
  logic data_wr;
  logic ctrl_wr;
  logic div_end;

  assign sel     = ~sser_n & ~ba13 & ba12;
  assign bus_wr  = sel & ~br_w & wr_stb;
  assign bus_rd  = sel & br_w;
  assign data_wr = bus_wr & (ba7_4 == 4'h0);
  assign ctrl_wr = bus_wr & (ba7_4 == 4'h8);

  assign rd_oe   = bus_rd;
  assign rd_data = (bus_rd && ba7_4 == 4'h0) ? {6'b0, ovr_q, busy_q} : 8'h00;

  assign div_end = (div_q == 8'd0);
  // Next word after the bit just sent on the sclk_o falling edge.
  assign shift_d = dir_q ? (shift_q >> 1) : (shift_q << 1);

  assign sdwr   = sdwr_q;
  assign sclk_o = sclk_q;
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      div_q       <= 8'd0;
      sdwr_q      <= 1'b1;
      sclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      lsb_first_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Overrun set comes first so a same-cycle clear takes priority.
      if (data_wr && busy_q) begin
        ovr_q <= 1'b1;
      end
      if (ctrl_wr) begin
        lsb_first_q <= bd_in[0];
        if (bd_in[1]) begin
          ovr_q <= 1'b0;
        end
      end

      case (state_q)
        IDLE: begin
          if (data_wr) begin
            shift_q <= bd_in;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          dir_q   <= lsb_first_q;
          sdwr_q  <= lsb_first_q ? shift_q[0] : shift_q[DATA_W-1];
          cnt_q   <= CNT_W'(DATA_W);
          div_q   <= 8'(CLK_DIV - 1);
          state_q <= LOW;
        end
        LOW: begin
          if (div_end) begin
            sclk_q  <= 1'b1;
            div_q   <= 8'(CLK_DIV - 1);
            state_q <= HIGH;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        HIGH: begin
          if (div_end) begin
            sclk_q <= 1'b0;
            div_q  <= 8'(CLK_DIV - 1);
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              sdwr_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_d;
              sdwr_q  <= dir_q ? shift_d[0] : shift_d[DATA_W-1];
              state_q <= LOW;
            end
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        STOP: begin
          if (div_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_wr_shifter.sv
// Self-checking bench for ser_wr_shifter: serial bits are scoreboarded against
// a queue filled at each DATA write; transfers and decode cases come from tables.
module tb_ser_wr_shifter;
  localparam int DW       = 8;
  localparam int CD       = 4;
  localparam int BUSY_LEN = 1 + 2 * CD * DW + CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sser_n = 1'b1;
  logic          ba13 = 1'b0;
  logic          ba12 = 1'b1;
  logic [3:0]    ba7_4 = 4'h0;
  logic          br_w = 1'b1;
  logic          wr_stb = 1'b0;
  logic [DW-1:0] bd_in = '0;
  logic [7:0]    rd_data;
  logic          rd_oe;
  logic          sdwr;
  logic          sclk_o;
  logic          busy;
  logic          done;

  ser_wr_shifter #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba7_4(ba7_4), .br_w(br_w), .wr_stb(wr_stb), .bd_in(bd_in),
    .rd_data(rd_data), .rd_oe(rd_oe), .sdwr(sdwr), .sclk_o(sclk_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];
  int   blen = 0;
  int   last_blen = 0;
  int   done_cnt = 0;
  logic prev_sclk = 1'b0;
  logic prev_sdwr = 1'b1;
  logic prev_busy = 1'b0;
  bit   model_lsb = 1'b0;

  typedef struct {
    bit         lsb;
    logic [7:0] data;
  } xfer_vec_t;

  typedef struct {
    logic       sser_n;
    logic       ba13;
    logic       ba12;
    logic [3:0] sel;
    bit         do_wr;
    logic       exp_oe;
    logic [7:0] exp_rd;
  } dec_vec_t;

  xfer_vec_t xfer_tab[4];
  dec_vec_t  dec_tab[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: one expected bit popped at every sclk_o rise.
  always @(negedge clk) begin : mon
    bit e;
    if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("serial_bit", sdwr, e);
      end
    end
    if (sclk_o === 1'b1 && prev_sclk === 1'b1) check("sdwr_stable_high", sdwr, prev_sdwr);
    if (busy === 1'b1) blen++;
    else if (prev_busy === 1'b1) begin
      last_blen = blen;
      blen = 0;
    end
    if (done === 1'b1) done_cnt++;
    prev_sclk = sclk_o;
    prev_sdwr = sdwr;
    prev_busy = busy;
  end

  task automatic idle_bus();
    sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b1; ba7_4 = 4'h0;
    br_w = 1'b1; wr_stb = 1'b0; bd_in = '0;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [7:0] d);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba7_4 = a;
    br_w = 1'b0; wr_stb = 1'b1; bd_in = d;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    drive_write(a, d);
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic status_read(input string name, input logic [7:0] exp);
    #1;
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; ba7_4 = 4'h0; br_w = 1'b1;
    #1;
    check({name, "_oe"}, rd_oe, 1);
    check(name, rd_data, exp);
    idle_bus();
  endtask

  task automatic push_bits(input logic [7:0] d, input bit lsb);
    for (int i = 0; i < DW; i++) exp_q.push_back(lsb ? d[i] : d[DW-1-i]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
      n++;
    end
    check({name, "_done_seen"}, n < 400, 1);
    @(posedge clk); #1;
  endtask

  task automatic post_xfer_checks(input string name, input int exp_done);
    check({name, "_busy_len"}, last_blen, BUSY_LEN);
    check({name, "_done_cnt"}, done_cnt, exp_done);
    check({name, "_sdwr_idle"}, sdwr, 1);
    check({name, "_sclk_idle"}, sclk_o, 0);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_bits_left"}, exp_q.size(), 0);
  endtask

  task automatic run_xfer(input string name, input logic [7:0] d, input bit lsb);
    bus_write(4'h8, {7'b0, lsb});
    model_lsb = lsb;
    done_cnt = 0;
    push_bits(d, model_lsb);
    bus_write(4'h0, d);
    check({name, "_busy_rise"}, busy, 1);
    wait_done(name);
    post_xfer_checks(name, 1);
    $display("xfer %s data=%02h lsb_first=%0d busy_len=%0d", name, d, lsb, last_blen);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rises;
    logic p;

    xfer_tab[0] = '{1'b0, 8'hA5};
    xfer_tab[1] = '{1'b1, 8'h3C};
    xfer_tab[2] = '{1'b1, 8'h80};
    xfer_tab[3] = '{1'b0, 8'h01};

    dec_tab[0] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00};
    dec_tab[1] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00};
    dec_tab[2] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00};
    dec_tab[3] = '{1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 8'h00};
    dec_tab[4] = '{1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 8'h00};
    dec_tab[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 8'h00};

    // Reset state
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sdwr", sdwr, 1);
    check("rst_sclk", sclk_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_oe", rd_oe, 0);
    check("rst_rd_data", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    status_read("rst_status", 8'h00);

    // Table of plain transfers (first row is A5 MSB-first)
    for (int i = 0; i < 4; i++) run_xfer($sformatf("tab%0d", i), xfer_tab[i].data, xfer_tab[i].lsb);

    // LSB-first with a CTRL rewrite mid-transfer
    bus_write(4'h8, 8'h01);
    model_lsb = 1'b1;
    done_cnt = 0;
    push_bits(8'h01, model_lsb);
    bus_write(4'h0, 8'h01);
    repeat (20) @(posedge clk);
    bus_write(4'h8, 8'h00);
    model_lsb = 1'b0;
    wait_done("t2");
    post_xfer_checks("t2", 1);
    $display("xfer t2 data=01 lsb_first=1 ctrl rewritten mid-transfer");

    // Overrun: second DATA write while busy is discarded
    done_cnt = 0;
    push_bits(8'hFF, model_lsb);
    bus_write(4'h0, 8'hFF);
    bus_write(4'h0, 8'h00);
    status_read("t3_status_busy", 8'h03);
    wait_done("t3");
    post_xfer_checks("t3", 1);
    repeat (10) @(posedge clk);
    #1;
    check("t3_no_second_xfer", busy, 0);
    status_read("t3_status_after", 8'h02);
    bus_write(4'h8, 8'h02);
    status_read("t3_status_cleared", 8'h00);
    $display("xfer t3 data=FF overrun write discarded and cleared");

    // DATA write landing in the done cycle
    done_cnt = 0;
    push_bits(8'h96, model_lsb);
    bus_write(4'h0, 8'h96);
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
      n++;
    end
    check("t4_first_done_seen", n < 400, 1);
    push_bits(8'h3C, model_lsb);
    drive_write(4'h0, 8'h3C);
    @(posedge clk); #1;
    idle_bus();
    check("t4_busy_reassert", busy, 1);
    status_read("t4_status_no_ovr", 8'h01);
    wait_done("t4");
    post_xfer_checks("t4", 2);
    $display("xfer t4 data=96 then 3C written in done cycle");

    // Reset during the fourth HIGH phase
    done_cnt = 0;
    push_bits(8'hC3, model_lsb);
    bus_write(4'h0, 8'hC3);
    rises = 0;
    p = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      if (sclk_o === 1'b1 && p === 1'b0) rises++;
      p = sclk_o;
      if (rises == 4) break;
      n++;
    end
    check("t5_fourth_high_seen", rises, 4);
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_high", sclk_o, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_sclk", sclk_o, 0);
    check("t5_rst_sdwr", sdwr, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    exp_q.delete();
    model_lsb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done_pulse", done_cnt, 0);
    $display("xfer t5 data=C3 aborted by reset");
    run_xfer("t5_after_rst", 8'h5A, 1'b0);

    // Decode negatives and non-status reads
    for (int i = 0; i < 6; i++) begin
      if (dec_tab[i].do_wr) begin
        @(posedge clk); #1;
        sser_n = dec_tab[i].sser_n; ba13 = dec_tab[i].ba13; ba12 = dec_tab[i].ba12;
        ba7_4 = dec_tab[i].sel; br_w = 1'b0; wr_stb = 1'b1; bd_in = 8'h55;
        @(posedge clk); #1;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("dec%0d_no_xfer", i), busy, 0);
        status_read($sformatf("dec%0d_status", i), 8'h00);
      end
      #1;
      sser_n = dec_tab[i].sser_n; ba13 = dec_tab[i].ba13; ba12 = dec_tab[i].ba12;
      ba7_4 = dec_tab[i].sel; br_w = 1'b1; wr_stb = 1'b0;
      #1;
      check($sformatf("dec%0d_rd_oe", i), rd_oe, dec_tab[i].exp_oe);
      check($sformatf("dec%0d_rd_data", i), rd_data, dec_tab[i].exp_rd);
      idle_bus();
      $display("decode row %0d sser_n=%0b ba13=%0b ba12=%0b sel=%0h", i,
               dec_tab[i].sser_n, dec_tab[i].ba13, dec_tab[i].ba12, dec_tab[i].sel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
